// File: rtl/ext_mem_responder_pkg.sv
// Shared types and defaults for the external-load responder in front of the CPU data RAM.
package ext_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int unsigned DEF_DEPTH_WORDS = 64;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_CNT_W       = 16;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ext_mem_responder_sync_fifo.sv
// Small synchronous FIFO; reset flushes pointers and count, storage is left as-is.
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Data-RAM responder: buffers external preload writes, arbitrates them against core stores,
// and reports when memory is consistent so the core may run.
module ext_mem_responder
  import ext_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_hold,
  input  logic             Ext_MemWrite,
  input  logic [31:0]      Ext_DataAdr,
  input  logic [31:0]      Ext_WriteData,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             ext_busy,
  output logic             ext_err,
  output logic [CNT_W-1:0] load_count,
  output logic             mem_ready
);

  localparam int IW = idx_w(DEPTH_WORDS);
  localparam int EW = IW + 32;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]   ram [DEPTH_WORDS];
  state_t        state;
  logic          hold_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_count;
  logic [EW-1:0] fifo_din;
  logic [EW-1:0] fifo_dout;
  logic          ext_aligned;
  logic          ext_in_range;
  logic          ext_push;
  logic          ext_reject;
  logic          core_wr;
  logic          commit;
  logic [IW-1:0] core_idx;
  logic [IW-1:0] commit_idx;
  logic [31:0]   commit_data;
  logic          unused_bits;

  assign ext_aligned  = (Ext_DataAdr[1:0] == 2'b00);
  assign ext_in_range = ~|Ext_DataAdr[31:IW+2];
  assign ext_push     = Ext_MemWrite & ext_aligned & ext_in_range & ~fifo_full;
  // A full FIFO rejects even when a pop frees a slot in the same cycle
  assign ext_reject   = Ext_MemWrite & (~ext_aligned | ~ext_in_range | fifo_full);

  assign core_wr      = (state == ST_RUN) & MemWrite;
  assign commit       = ~fifo_empty & ~core_wr;

  assign fifo_din     = {Ext_DataAdr[IW+1:2], Ext_WriteData};
  assign commit_idx   = fifo_dout[EW-1:32];
  assign commit_data  = fifo_dout[31:0];
  assign core_idx     = DataAdr[IW+1:2];

  assign ReadData     = ram[core_idx];
  assign ext_busy     = fifo_full;
  assign unused_bits  = ^{DataAdr[31:IW+2], DataAdr[1:0], fifo_count};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ext_push),
    .pop   (commit),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // RAM survives reset; writes are suppressed during it so reset is a clean cut mid-drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (core_wr)     ram[core_idx]   <= WriteData;
      else if (commit) ram[commit_idx] <= commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD;
      mem_ready  <= 1'b0;
      ext_err    <= 1'b0;
      load_count <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_q <= core_hold;
      if (ext_reject) ext_err <= 1'b1;

      if (core_hold && !hold_q)
        load_count <= commit ? CNT_W'(1) : '0;
      else if (commit && load_count != CNT_MAX)
        load_count <= load_count + 1'b1;

      unique case (state)
        ST_LOAD: begin
          if (!core_hold) state <= ST_DRAIN;
          mem_ready <= 1'b0;
        end
        ST_DRAIN: begin
          if (core_hold) begin
            state     <= ST_LOAD;
            mem_ready <= 1'b0;
          end else if (fifo_empty && !ext_push) begin
            state     <= ST_RUN;
            mem_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_hold) begin
            state     <= ST_LOAD;
            mem_ready <= 1'b0;
          end
        end
        default: begin
          state     <= ST_LOAD;
          mem_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed scoreboard bench for ext_mem_responder: stimulus queues expectations, a monitor compares on the falling edge.
module tb_ext_mem_responder;

  localparam int S_RD   = 0;
  localparam int S_LC   = 1;
  localparam int S_RDY  = 2;
  localparam int S_ERR  = 3;
  localparam int S_BUSY = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_hold;
  logic        Ext_MemWrite;
  logic [31:0] Ext_DataAdr;
  logic [31:0] Ext_WriteData;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ext_busy;
  logic        ext_err;
  logic [15:0] load_count;
  logic        mem_ready;

  chk_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  ext_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .core_hold     (core_hold),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_DataAdr   (Ext_DataAdr),
    .Ext_WriteData (Ext_WriteData),
    .MemWrite      (MemWrite),
    .DataAdr       (DataAdr),
    .WriteData     (WriteData),
    .ReadData      (ReadData),
    .ext_busy      (ext_busy),
    .ext_err       (ext_err),
    .load_count    (load_count),
    .mem_ready     (mem_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sel)
        S_RD:    act = ReadData;
        S_LC:    act = {16'h0, load_count};
        S_RDY:   act = {31'h0, mem_ready};
        S_ERR:   act = {31'h0, ext_err};
        S_BUSY:  act = {31'h0, ext_busy};
        default: act = 32'hxxxx_xxxx;
      endcase
      n_checks++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.nm, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
    chk_t c;
    c.sel = sel;
    c.exp = v;
    c.nm  = nm;
    q.push_back(c);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    DataAdr = a;
    expect_val(S_RD, v, nm);
    tick();
  endtask

  task automatic ext_wr(input logic [31:0] a, input logic [31:0] d);
    Ext_MemWrite  = 1'b1;
    Ext_DataAdr   = a;
    Ext_WriteData = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; core_hold = 1'b1;
    Ext_MemWrite = 1'b0; Ext_DataAdr = '0; Ext_WriteData = '0;
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (load_count !== 16'h0 || mem_ready !== 1'b0 || ext_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_direct: lc=0x%04h rdy=%b err=%b", load_count, mem_ready, ext_err);
    end
    expect_val(S_LC, 0, "reset_load_count");
    expect_val(S_RDY, 0, "reset_mem_ready");
    expect_val(S_ERR, 0, "reset_ext_err");
    expect_val(S_BUSY, 0, "reset_ext_busy");

    // two preload writes commit while held
    ext_wr(32'h00, 32'hAAAA_0001); tick();
    ext_wr(32'h04, 32'hBBBB_0002); tick();
    Ext_MemWrite = 1'b0; tick();
    n_checks++;
    if (load_count !== 16'd2 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL t1_direct: lc=0x%04h rdy=%b", load_count, mem_ready);
    end
    expect_val(S_LC, 2, "t1_load_count");
    expect_val(S_RDY, 0, "t1_mem_ready");
    rd(32'h00, 32'hAAAA_0001, "t1_ram0");
    rd(32'h04, 32'hBBBB_0002, "t1_ram1");

    // misaligned and out-of-range writes are rejected; RAM survives reset
    do_reset();
    expect_val(S_ERR, 0, "t3_err_after_reset");
    expect_val(S_LC, 0, "t3_lc_after_reset");
    ext_wr(32'h102, 32'h1111_1111); tick();
    ext_wr(32'h100, 32'h2222_2222); tick();
    Ext_MemWrite = 1'b0; tick(); tick();
    expect_val(S_ERR, 1, "t3_ext_err");
    expect_val(S_LC, 0, "t3_load_count");
    rd(32'h00, 32'hAAAA_0001, "t3_ram0_kept");
    rd(32'h04, 32'hBBBB_0002, "t3_ram1_kept");

    // fresh load window: sentinels, then release to RUN
    do_reset();
    tick();
    ext_wr(32'h0C, 32'hDEAD_0003); tick();
    ext_wr(32'h50, 32'hDEAD_0014); tick();
    ext_wr(32'h7C, 32'hDEAD_001F); tick();
    Ext_MemWrite = 1'b0; tick();
    expect_val(S_LC, 3, "pre_load_count");
    core_hold = 1'b0; tick();
    expect_val(S_RDY, 0, "pre_drain_not_ready");
    tick();
    expect_val(S_RDY, 1, "pre_run_ready");

    // fill FIFO behind core stores, then a write while full with a pop
    MemWrite = 1'b1; DataAdr = 32'h20; WriteData = 32'hC0C0_0008;
    for (int k = 0; k < 4; k++) begin
      ext_wr(32'h40 + 32'(4 * k), 32'h5000_0010 + 32'(k));
      tick();
    end
    expect_val(S_BUSY, 1, "t2_busy_full");
    expect_val(S_ERR, 0, "t2_err_before_drop");
    MemWrite = 1'b0;
    ext_wr(32'h50, 32'h5000_0014); tick();
    expect_val(S_ERR, 1, "t2_err_after_drop");
    expect_val(S_BUSY, 0, "t2_busy_after_pop");
    Ext_MemWrite = 1'b0; tick(); tick(); tick();
    expect_val(S_LC, 7, "t2_load_count");
    for (int k = 0; k < 4; k++)
      rd(32'h40 + 32'(4 * k), 32'h5000_0010 + 32'(k), "t2_ram_word");
    rd(32'h50, 32'hDEAD_0014, "t2_dropped_word");
    rd(32'h20, 32'hC0C0_0008, "t2_core_word");

    // core store beats a same-cycle external write
    MemWrite = 1'b1; DataAdr = 32'h08; WriteData = 32'hC0DE_0002;
    ext_wr(32'h0C, 32'hE0E0_0003); tick();
    MemWrite = 1'b0; Ext_MemWrite = 1'b0;
    rd(32'h0C, 32'hDEAD_0003, "t5_ext_not_yet");
    rd(32'h0C, 32'hE0E0_0003, "t5_ext_committed");
    expect_val(S_LC, 8, "t5_load_count");
    rd(32'h08, 32'hC0DE_0002, "t5_core_word");

    // full FIFO drained through LOAD/DRAIN, mem_ready one edge after last commit
    MemWrite = 1'b1; DataAdr = 32'h20; WriteData = 32'hC0C0_0008;
    for (int k = 0; k < 4; k++) begin
      ext_wr(32'h60 + 32'(4 * k), 32'hF000_0018 + 32'(k));
      tick();
    end
    Ext_MemWrite = 1'b0; core_hold = 1'b1; tick();
    expect_val(S_RDY, 0, "t4_load_ready");
    expect_val(S_LC, 0, "t4_lc_cleared");
    expect_val(S_BUSY, 1, "t4_busy");
    core_hold = 1'b0; MemWrite = 1'b0; tick();
    expect_val(S_LC, 1, "t4_lc_first");
    expect_val(S_BUSY, 0, "t4_busy_off");
    expect_val(S_RDY, 0, "t4_ready_b");
    tick();
    expect_val(S_RDY, 0, "t4_ready_c");
    tick();
    expect_val(S_RDY, 0, "t4_ready_d");
    tick();
    expect_val(S_LC, 4, "t4_lc_last_commit");
    expect_val(S_RDY, 0, "t4_ready_at_last_commit");
    tick();
    expect_val(S_RDY, 1, "t4_ready_after");
    for (int k = 0; k < 4; k++)
      rd(32'h60 + 32'(4 * k), 32'hF000_0018 + 32'(k), "t4_ram_word");

    // reset mid-DRAIN with three entries still queued
    MemWrite = 1'b1; DataAdr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      ext_wr(32'h70 + 32'(4 * k), 32'hA600_001C + 32'(k));
      tick();
    end
    Ext_MemWrite = 1'b0; core_hold = 1'b1; tick();
    core_hold = 1'b0; MemWrite = 1'b0; tick();
    expect_val(S_ERR, 1, "t6_err_before_reset");
    do_reset();
    expect_val(S_RDY, 0, "t6_ready");
    expect_val(S_LC, 0, "t6_load_count");
    expect_val(S_ERR, 0, "t6_ext_err");
    expect_val(S_BUSY, 0, "t6_busy");
    tick(); tick();
    expect_val(S_RDY, 1, "t6_run_empty_fifo");
    expect_val(S_LC, 0, "t6_no_stale_commits");
    rd(32'h70, 32'hA600_001C, "t6_committed_kept");
    rd(32'h7C, 32'hDEAD_001F, "t6_pending_lost");

    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
